// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
package ttt_pkg;

    typedef enum logic [1:0] {
        WAIT_X = 2'b00,
        WAIT_O = 2'b01,
        CHECK  = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] XWIN = 2'b01;
    localparam logic [1:0] OWIN = 2'b10;
    localparam logic [1:0] DRAW = 2'b11;

    localparam int unsigned BOARD_CELLS = 9;

    // Cell masks for the three rows, three columns and two diagonals (row-major, bit 0 = top-left).
    localparam logic [BOARD_CELLS-1:0] WIN_LINES [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    // One-hot mask for a cell index; indices past the board yield zero.
    function automatic logic [BOARD_CELLS-1:0] cell_mask(input logic [3:0] pos);
        cell_mask = BOARD_CELLS'(1) << pos;
    endfunction

endpackage

// File: rtl/ttt_line_detect.sv
// Combinational detector: high when the board covers any complete win line.
module ttt_line_detect
    import ttt_pkg::*;
(
    input  logic [BOARD_CELLS-1:0] board,
    output logic                   win
);

    // Compare the board against every win-line mask.
    always_comb begin
        win = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((board & WIN_LINES[i]) == WIN_LINES[i]) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn controller: accepts alternating X/O moves, rejects
// illegal ones, and decides win/draw in a one-cycle CHECK state.
module ttt_turn_controller
    import ttt_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   new_game,
    input  logic                   move_valid,
    input  logic [3:0]             move_pos,
    output logic                   move_ready,
    output logic                   turn,
    output logic [BOARD_CELLS-1:0] xboard,
    output logic [BOARD_CELLS-1:0] oboard,
    output logic                   illegal,
    output logic                   game_over,
    output logic [1:0]             winner
);

    state_t                 state_q, state_d;
    logic [BOARD_CELLS-1:0] xboard_q, xboard_d;
    logic [BOARD_CELLS-1:0] oboard_q, oboard_d;
    logic                   turn_q, turn_d;
    logic                   illegal_q, illegal_d;
    logic                   game_over_q, game_over_d;
    logic [1:0]             winner_q, winner_d;

    logic [BOARD_CELLS-1:0] occupied;
    logic [BOARD_CELLS-1:0] pos_mask;
    logic                   move_legal;
    logic [BOARD_CELLS-1:0] mover_board;
    logic                   line_win;

    assign occupied   = xboard_q | oboard_q;
    assign pos_mask   = cell_mask(move_pos);
    assign move_legal = (move_pos <= 4'd8) && ((occupied & pos_mask) == '0);

    // Only the player who just moved can have completed a line.
    always_comb begin
        mover_board = turn_q ? oboard_q : xboard_q;
    end

    ttt_line_detect u_line_detect (
        .board (mover_board),
        .win   (line_win)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_X;
            xboard_q    <= '0;
            oboard_q    <= '0;
            turn_q      <= 1'b0;
            illegal_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= NONE;
        end else begin
            state_q     <= state_d;
            xboard_q    <= xboard_d;
            oboard_q    <= oboard_d;
            turn_q      <= turn_d;
            illegal_q   <= illegal_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    // Next-state logic: move acceptance, game decision and restart.
    always_comb begin
        state_d     = state_q;
        xboard_d    = xboard_q;
        oboard_d    = oboard_q;
        turn_d      = turn_q;
        illegal_d   = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        unique case (state_q)
            WAIT_X, WAIT_O: begin
                if (move_valid) begin
                    if (move_legal) begin
                        if (state_q == WAIT_X) begin
                            xboard_d = xboard_q | pos_mask;
                        end else begin
                            oboard_d = oboard_q | pos_mask;
                        end
                        state_d = CHECK;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                // A win takes precedence over a full board.
                if (line_win) begin
                    state_d     = DONE;
                    game_over_d = 1'b1;
                    winner_d    = turn_q ? OWIN : XWIN;
                end else if (&occupied) begin
                    state_d     = DONE;
                    game_over_d = 1'b1;
                    winner_d    = DRAW;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = turn_q ? WAIT_X : WAIT_O;
                end
            end
            DONE: begin
                if (new_game) begin
                    state_d     = WAIT_X;
                    xboard_d    = '0;
                    oboard_d    = '0;
                    turn_d      = 1'b0;
                    game_over_d = 1'b0;
                    winner_d    = NONE;
                end
            end
            default: state_d = WAIT_X;
        endcase
    end

    assign move_ready = (state_q == WAIT_X) || (state_q == WAIT_O);
    assign turn       = turn_q;
    assign xboard     = xboard_q;
    assign oboard     = oboard_q;
    assign illegal    = illegal_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Directed self-checking bench for ttt_turn_controller.
module tb_ttt_turn_controller;

    logic       clk;
    logic       rst_n;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic       turn;
    logic [8:0] xboard;
    logic [8:0] oboard;
    logic       illegal;
    logic       game_over;
    logic [1:0] winner;

    int unsigned tests;
    int unsigned fails;

    ttt_turn_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .move_ready (move_ready),
        .turn       (turn),
        .xboard     (xboard),
        .oboard     (oboard),
        .illegal    (illegal),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Play one move: wait (bounded) for move_ready, present for one edge, then let CHECK pass.
    task automatic mv(input logic [3:0] p);
        int unsigned n;
        n = 0;
        while (!move_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!move_ready) begin
            tests++; fails++;
            $display("FAIL mv_wait_ready: move_ready=%0b required 1", move_ready);
        end
        move_valid = 1'b1;
        move_pos   = p;
        @(posedge clk); #1;
        move_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++; if (xboard !== 9'h000) begin fails++; $display("FAIL reset_xboard: got %0h required 0", xboard); end
        tests++; if (oboard !== 9'h000) begin fails++; $display("FAIL reset_oboard: got %0h required 0", oboard); end
        tests++; if (turn !== 1'b0) begin fails++; $display("FAIL reset_turn: got %0b required 0", turn); end
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %0b required 0", illegal); end
        tests++; if (game_over !== 1'b0) begin fails++; $display("FAIL reset_game_over: got %0b required 0", game_over); end
        tests++; if (winner !== 2'b00) begin fails++; $display("FAIL reset_winner: got %0b required 00", winner); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (move_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after_release: got %0b required 1", move_ready); end
    endtask

    task automatic test_x_win();
        mv(4'd0); mv(4'd3); mv(4'd1); mv(4'd4);
        tests++; if (game_over !== 1'b0) begin fails++; $display("FAIL xwin_not_over_early: got %0b required 0", game_over); end
        tests++; if (turn !== 1'b0) begin fails++; $display("FAIL xwin_turn_before_last: got %0b required 0", turn); end
        mv(4'd2);
        tests++; if (xboard !== 9'h007) begin fails++; $display("FAIL xwin_xboard: got %0h required 7", xboard); end
        tests++; if (oboard !== 9'h018) begin fails++; $display("FAIL xwin_oboard: got %0h required 18", oboard); end
        tests++; if (winner !== 2'b01) begin fails++; $display("FAIL xwin_winner: got %0b required 01", winner); end
        tests++; if (game_over !== 1'b1) begin fails++; $display("FAIL xwin_game_over: got %0b required 1", game_over); end
        tests++; if (move_ready !== 1'b0) begin fails++; $display("FAIL xwin_ready_done: got %0b required 0", move_ready); end
        tests++; if (turn !== 1'b0) begin fails++; $display("FAIL xwin_turn_held: got %0b required 0", turn); end
    endtask

    task automatic test_new_game();
        // Moves in DONE are ignored and raise no illegal pulse.
        move_valid = 1'b1; move_pos = 4'd5;
        @(posedge clk); #1;
        move_valid = 1'b0;
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL done_move_illegal: got %0b required 0", illegal); end
        tests++; if (xboard !== 9'h007) begin fails++; $display("FAIL done_move_xboard: got %0h required 7", xboard); end
        tests++; if (game_over !== 1'b1) begin fails++; $display("FAIL done_hold: got %0b required 1", game_over); end
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        tests++; if (xboard !== 9'h000) begin fails++; $display("FAIL ng_xboard: got %0h required 0", xboard); end
        tests++; if (oboard !== 9'h000) begin fails++; $display("FAIL ng_oboard: got %0h required 0", oboard); end
        tests++; if (winner !== 2'b00) begin fails++; $display("FAIL ng_winner: got %0b required 00", winner); end
        tests++; if (turn !== 1'b0) begin fails++; $display("FAIL ng_turn: got %0b required 0", turn); end
        tests++; if (game_over !== 1'b0) begin fails++; $display("FAIL ng_game_over: got %0b required 0", game_over); end
        tests++; if (move_ready !== 1'b1) begin fails++; $display("FAIL ng_ready: got %0b required 1", move_ready); end
    endtask

    task automatic test_illegal();
        mv(4'd4);
        tests++; if (turn !== 1'b1) begin fails++; $display("FAIL ill_turn_o: got %0b required 1", turn); end
        move_valid = 1'b1; move_pos = 4'd4;
        @(posedge clk); #1;
        move_valid = 1'b0;
        tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL ill_occupied_pulse: got %0b required 1", illegal); end
        tests++; if (oboard !== 9'h000) begin fails++; $display("FAIL ill_oboard: got %0h required 0", oboard); end
        tests++; if (xboard !== 9'h010) begin fails++; $display("FAIL ill_xboard: got %0h required 10", xboard); end
        tests++; if (turn !== 1'b1) begin fails++; $display("FAIL ill_turn_held: got %0b required 1", turn); end
        tests++; if (move_ready !== 1'b1) begin fails++; $display("FAIL ill_ready: got %0b required 1", move_ready); end
        @(posedge clk); #1;
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ill_pulse_width: got %0b required 0", illegal); end
        move_valid = 1'b1; move_pos = 4'd9;
        @(posedge clk); #1;
        move_valid = 1'b0;
        tests++; if (illegal !== 1'b1) begin fails++; $display("FAIL ill_range_pulse: got %0b required 1", illegal); end
        tests++; if (oboard !== 9'h000) begin fails++; $display("FAIL ill_range_oboard: got %0h required 0", oboard); end
        @(posedge clk); #1;
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL ill_range_width: got %0b required 0", illegal); end
        // new_game outside DONE has no effect.
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        tests++; if (xboard !== 9'h010) begin fails++; $display("FAIL ng_ignored_xboard: got %0h required 10", xboard); end
        tests++; if (turn !== 1'b1) begin fails++; $display("FAIL ng_ignored_turn: got %0b required 1", turn); end
    endtask

    task automatic test_draw();
        apply_reset();
        mv(4'd0); mv(4'd1); mv(4'd2); mv(4'd4); mv(4'd3); mv(4'd5); mv(4'd7); mv(4'd6);
        tests++; if (game_over !== 1'b0) begin fails++; $display("FAIL draw_not_over_early: got %0b required 0", game_over); end
        mv(4'd8);
        tests++; if (winner !== 2'b11) begin fails++; $display("FAIL draw_winner: got %0b required 11", winner); end
        tests++; if ((xboard | oboard) !== 9'h1FF) begin fails++; $display("FAIL draw_full: got %0h required 1ff", xboard | oboard); end
        tests++; if (xboard !== 9'h18D) begin fails++; $display("FAIL draw_xboard: got %0h required 18d", xboard); end
        tests++; if (game_over !== 1'b1) begin fails++; $display("FAIL draw_game_over: got %0b required 1", game_over); end
    endtask

    task automatic test_ninth_move_win();
        apply_reset();
        mv(4'd0); mv(4'd1); mv(4'd3); mv(4'd2); mv(4'd7); mv(4'd4); mv(4'd8); mv(4'd5); mv(4'd6);
        tests++; if (winner !== 2'b01) begin fails++; $display("FAIL ninth_winner: got %0b required 01", winner); end
        tests++; if (xboard !== 9'h1C9) begin fails++; $display("FAIL ninth_xboard: got %0h required 1c9", xboard); end
        tests++; if (oboard !== 9'h036) begin fails++; $display("FAIL ninth_oboard: got %0h required 36", oboard); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [9];
        int unsigned acc;
        logic r;
        logic exp_r;
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        apply_reset();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            move_valid = 1'b1;
            move_pos   = seq[acc];
            @(negedge clk);
            r     = move_ready;
            exp_r = ((i % 2) == 0) && (i < 14);
            tests++; if (r !== exp_r) begin fails++; $display("FAIL b2b_ready cycle %0d: got %0b required %0b", i, r, exp_r); end
            @(posedge clk); #1;
            if (r) acc++;
            tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL b2b_illegal cycle %0d: got %0b required 0", i, illegal); end
        end
        move_valid = 1'b0;
        tests++; if (acc != 7) begin fails++; $display("FAIL b2b_accepts: got %0d required 7", acc); end
        tests++; if (xboard !== 9'h055) begin fails++; $display("FAIL b2b_xboard: got %0h required 55", xboard); end
        tests++; if (oboard !== 9'h02A) begin fails++; $display("FAIL b2b_oboard: got %0h required 2a", oboard); end
        tests++; if (winner !== 2'b01) begin fails++; $display("FAIL b2b_winner: got %0b required 01", winner); end
    endtask

    task automatic test_reset_in_check();
        apply_reset();
        mv(4'd0); mv(4'd1);
        move_valid = 1'b1; move_pos = 4'd2;
        @(posedge clk); #1;
        move_valid = 1'b0;
        tests++; if (move_ready !== 1'b0) begin fails++; $display("FAIL ric_in_check: got %0b required 0", move_ready); end
        tests++; if (xboard !== 9'h005) begin fails++; $display("FAIL ric_xboard_pre: got %0h required 5", xboard); end
        rst_n = 1'b0;
        #1;
        tests++; if (xboard !== 9'h000) begin fails++; $display("FAIL ric_xboard_cleared: got %0h required 0", xboard); end
        tests++; if (oboard !== 9'h000) begin fails++; $display("FAIL ric_oboard_cleared: got %0h required 0", oboard); end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (move_ready !== 1'b1) begin fails++; $display("FAIL ric_ready_after: got %0b required 1", move_ready); end
        tests++; if (turn !== 1'b0) begin fails++; $display("FAIL ric_turn: got %0b required 0", turn); end
        mv(4'd4);
        tests++; if (xboard !== 9'h010) begin fails++; $display("FAIL ric_first_move: got %0h required 10", xboard); end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
        @(posedge clk); #1;
        test_reset();
        test_x_win();
        test_new_game();
        test_illegal();
        test_draw();
        test_ninth_move_win();
        test_back_to_back();
        test_reset_in_check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
